sub32_serial: RTL and testbench

SUB32_SERIAL -- requirements
Module: sub32_serial

---
 rtl/sub32_serial.sv | 122 ++++++++++++
 tb/tb_sub32_serial.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sub32_serial.sv
// Serial 32-bit subtractor: src1 - src2 computed one 4-bit slice per cycle, LSB slice first.
// Start accepted in IDLE/DONE; 8 RUN cycles, then a one-cycle done pulse; start during RUN is ignored.
module sub32_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        borrow,
  output logic        zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [27:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        borrow_q, borrow_d;
  logic        zero_q, zero_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic [3:0]  a_sl, b_sl;
  logic [4:0]  sum;
  logic [31:0] final_res;

  always_comb begin
    accept    = start && (state_q != RUN);
    a_sl      = a_q[{cnt_q, 2'b00} +: 4];
    b_sl      = b_q[{cnt_q, 2'b00} +: 4];
    sum       = {1'b0, a_sl} + {1'b0, ~b_sl} + {4'b0000, carry_q};
    // Completed slices sit in acc_q[27:0]; the slice finishing now supplies the top nibble.
    final_res = {sum[3:0], acc_q};

    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    borrow_d   = borrow_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    case (state_q)
      RUN: begin
        acc_d   = {sum[3:0], acc_q[27:4]};
        carry_d = sum[4];
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d    = DONE;
          result_d   = final_res;
          borrow_d   = ~sum[4];
          zero_d     = (final_res == 32'd0);
          overflow_d = (a_q[31] ^ b_q[31]) & (final_res[31] ^ a_q[31]);
        end
      end
      default: begin
        if (accept) begin
          state_d = RUN;
          a_d     = src1;
          b_d     = src2;
          cnt_d   = 3'd0;
          carry_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      carry_q    <= 1'b0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      acc_q      <= 28'd0;
      result_q   <= 32'd0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      borrow_q   <= borrow_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign borrow   = borrow_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Directed bench for sub32_serial: reset, basic/underflow/overflow vectors, ignored start, back-to-back, abort.
module tb_sub32_serial;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] src1, src2;
  logic        busy, done, borrow, zero, overflow;
  logic [31:0] result;

  int vectors = 0;
  int errors  = 0;

  sub32_serial dut (
    .clk(clk), .rst(rst), .start(start), .src1(src1), .src2(src2),
    .busy(busy), .done(done), .result(result),
    .borrow(borrow), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Launches (unless already launched), then observes up to 20 cycles. Reports done cycle,
  // RUN cycle count, whether result held prev_res throughout RUN, and the values at done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit launched,
                       input int pulse_at, input bit chain,
                       input logic [31:0] na, input logic [31:0] nb,
                       input logic [31:0] prev_res,
                       output int done_cyc, output int busy_cnt, output bit stable,
                       output logic [31:0] r, output logic [3:0] flags);
    done_cyc = 0; busy_cnt = 0; stable = 1'b1; r = 'x; flags = 'x;
    if (!launched) begin
      @(posedge clk); #1 start = 1'b1; src1 = a; src2 = b;
      @(posedge clk); #1 start = 1'b0; src1 = $urandom; src2 = $urandom;
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == pulse_at) begin start = 1'b1; src1 = 32'h0000FFFF; src2 = 32'h1; end
      if (pulse_at != 0 && cyc == pulse_at + 1) start = 1'b0;
      if (busy) begin
        busy_cnt++;
        if (result !== prev_res) stable = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        r = result;
        flags = {busy, borrow, zero, overflow};
        break;
      end
    end
    if (chain) begin
      start = 1'b1; src1 = na; src2 = nb;
      @(posedge clk); #1 start = 1'b0; src1 = $urandom; src2 = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; src1 = 32'hFFFFFFFF; src2 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done); end
    vectors++; if (result !== 32'd0 || {borrow, zero, overflow} !== 3'b000) begin errors++; $display("FAIL reset_data result=%h flags=%b want 0 000", result, {borrow, zero, overflow}); end
    @(negedge clk); rst = 1'b0; start = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prev, input logic [31:0] er, input logic [2:0] ef);
    int dc, bc; bit st; logic [31:0] r; logic [3:0] f;
    do_op(a, b, 1'b0, 0, 1'b0, 32'h0, 32'h0, prev, dc, bc, st, r, f);
    vectors++; if (dc !== 9 || bc !== 8) begin errors++; $display("FAIL %s_timing done_cycle=%0d busy_cycles=%0d want 9 8", nm, dc, bc); end
    vectors++; if (st !== 1'b1) begin errors++; $display("FAIL %s_hold result changed during RUN, want held %h", nm, prev); end
    vectors++; if (r !== er || f !== {1'b0, ef}) begin errors++; $display("FAIL %s result=%h busy,b,z,o=%b want %h 0%b", nm, r, f, er, ef); end
  endtask

  task automatic test_basic();
    check_op("basic", 32'd5, 32'd3, 32'd0, 32'h00000002, 3'b000);
  endtask

  task automatic test_underflow();
    check_op("underflow", 32'h0, 32'h1, 32'h00000002, 32'hFFFFFFFF, 3'b100);
  endtask

  task automatic test_overflow();
    check_op("ovf_neg", 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 3'b001);
    check_op("ovf_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 3'b101);
  endtask

  task automatic test_ignore_start();
    int dc, bc, extra; bit st; logic [31:0] r; logic [3:0] f;
    do_op(32'h1234, 32'h1234, 1'b0, 3, 1'b0, 32'h0, 32'h0, 32'h80000000, dc, bc, st, r, f);
    vectors++; if (dc !== 9 || bc !== 8) begin errors++; $display("FAIL ignore_timing done_cycle=%0d busy_cycles=%0d want 9 8", dc, bc); end
    vectors++; if (r !== 32'h0 || f !== 4'b0010) begin errors++; $display("FAIL ignore_result result=%h busy,b,z,o=%b want 0 0010", r, f); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    vectors++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op active_cycles=%0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int dc, bc; bit st; logic [31:0] r; logic [3:0] f;
    do_op(32'd9, 32'd4, 1'b0, 0, 1'b1, 32'd2, 32'd7, 32'h0, dc, bc, st, r, f);
    vectors++; if (dc !== 9 || r !== 32'd5 || f !== 4'b0000) begin errors++; $display("FAIL b2b_first done_cycle=%0d result=%h flags=%b want 9 5 0000", dc, r, f); end
    do_op(32'd0, 32'd0, 1'b1, 0, 1'b0, 32'h0, 32'h0, 32'd5, dc, bc, st, r, f);
    vectors++; if (dc !== 9 || bc !== 8) begin errors++; $display("FAIL b2b_timing done_cycle=%0d busy_cycles=%0d want 9 8", dc, bc); end
    vectors++; if (st !== 1'b1) begin errors++; $display("FAIL b2b_hold previous result not held during RUN, want %h", 32'd5); end
    vectors++; if (r !== 32'hFFFFFFFB || f !== 4'b0100) begin errors++; $display("FAIL b2b_second result=%h flags=%b want fffffffb 0100", r, f); end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(posedge clk); #1 start = 1'b1; src1 = 32'h10; src2 = 32'h1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_running busy=%b want 1", busy); end
    rst = 1'b1; #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctl busy=%b done=%b want 0 0", busy, done); end
    vectors++; if (result !== 32'd0 || {borrow, zero, overflow} !== 3'b000) begin errors++; $display("FAIL abort_data result=%h flags=%b want 0 000", result, {borrow, zero, overflow}); end
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    vectors++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done active_cycles=%0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
